// File: rtl/stream_chk_pkg.sv
// Shared types and constants for the stream_chk consumer/checker.
package stream_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stream_chk_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_INIT_DEFAULT = 16'hACE1;

endpackage

// File: rtl/stream_chk_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
module stream_chk_lfsr
  import stream_chk_pkg::*;
#(
  parameter logic [15:0] RST_VAL = LFSR_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        adv,
  input  logic [15:0] init,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= init;
    end else if (adv) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/stream_chk.sv
// Stream consumer/checker: accepts num_words words and compares them against an
// incrementing sequence from seed. Define STREAM_CHK_BP_EN for LFSR backpressure.
module stream_chk
  import stream_chk_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_INIT = LFSR_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] seed,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [DATA_W-1:0] first_err_data
);

  stream_chk_state_e state, state_nxt;

  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] exp_q;
  logic [CNT_W-1:0]  rx_nxt;
  logic              start_acc;
  logic              xfer;
  logic              last_xfer;
  logic              rdy_start;
  logic              rdy_run;

  assign start_acc = start && (state != RUN);
  assign xfer      = (state == RUN) && in_vld && in_rdy;
  assign rx_nxt    = rx_cnt + CNT_W'(1);
  assign last_xfer = xfer && (rx_nxt == num_q);

`ifdef STREAM_CHK_BP_EN
  logic [15:0] lfsr_q;

  stream_chk_lfsr #(
    .RST_VAL (LFSR_INIT)
  ) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .load (start_acc),
    .adv  (state == RUN),
    .init (LFSR_INIT),
    .q    (lfsr_q)
  );

  // The first ready value derives from the freshly reloaded LFSR contents.
  assign rdy_start = LFSR_INIT[1] | LFSR_INIT[0];
  assign rdy_run   = lfsr_q[1] | lfsr_q[0];
`else
  assign rdy_start = 1'b1;
  assign rdy_run   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_words == '0) ? DONE : RUN;
      RUN:        if (last_xfer) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_q          <= '0;
      exp_q          <= '0;
      in_rdy         <= 1'b0;
      err            <= 1'b0;
      err_cnt        <= '0;
      rx_cnt         <= '0;
      first_err_data <= '0;
    end else if (start_acc) begin
      num_q          <= num_words;
      exp_q          <= seed;
      rx_cnt         <= '0;
      err_cnt        <= '0;
      err            <= 1'b0;
      first_err_data <= '0;
      in_rdy         <= (num_words != '0) && rdy_start;
    end else if (state == RUN) begin
      if (xfer) begin
        rx_cnt <= rx_nxt;
        exp_q  <= exp_q + DATA_W'(1);
        if (in_data != exp_q) begin
          if (!err) first_err_data <= in_data;
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
      end
      in_rdy <= last_xfer ? 1'b0 : rdy_run;
    end else begin
      in_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_chk.sv
// Directed self-checking bench for stream_chk (works with or without STREAM_CHK_BP_EN).
module tb_stream_chk;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] num_words;
  logic [31:0] seed;
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_rdy;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] err_cnt;
  logic [15:0] rx_cnt;
  logic [31:0] first_err_data;

  int checks   = 0;
  int failures = 0;

  stream_chk dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .num_words      (num_words),
    .seed           (seed),
    .in_vld         (in_vld),
    .in_data        (in_data),
    .in_rdy         (in_rdy),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_cnt        (err_cnt),
    .rx_cnt         (rx_cnt),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] n, input logic [31:0] s);
    start     = 1'b1;
    num_words = n;
    seed      = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offers words base+i (with up to two substitutions) until n transfers occur.
  task automatic feed(input int n, input logic [31:0] base,
                      input int ci0, input logic [31:0] cv0,
                      input int ci1, input logic [31:0] cv1,
                      output int cycles, output int stalls);
    int  idx = 0;
    bit  hs;
    cycles = 0;
    stalls = 0;
    while (idx < n && cycles < 8 * n + 20) begin
      in_vld  = 1'b1;
      in_data = (idx == ci0) ? cv0 : (idx == ci1) ? cv1 : base + 32'(idx);
      hs      = in_rdy;
      if (!hs) stalls++;
      @(posedge clk);
      #1;
      if (hs) idx++;
      cycles++;
    end
    in_vld = 1'b0;
    if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
  endtask

  int cyc, stl;

  initial begin
    rstn = 1'b0; start = 1'b0; num_words = '0; seed = '0; in_vld = 1'b0; in_data = '0;
    #2;
    check("rst_in_rdy", {31'b0, in_rdy}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rx_cnt", {16'b0, rx_cnt}, 32'd0);
    check("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    check("rst_first_err", first_err_data, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Clean 8-word run from 0x10.
    do_start(16'd8, 32'h10);
    check("run8_busy", {31'b0, busy}, 32'd1);
    feed(8, 32'h10, -1, '0, -1, '0, cyc, stl);
`ifndef STREAM_CHK_BP_EN
    check("run8_cycles", 32'(cyc), 32'd8);
`endif
    check("run8_done", {31'b0, done}, 32'd1);
    check("run8_busy_off", {31'b0, busy}, 32'd0);
    check("run8_rx_cnt", {16'b0, rx_cnt}, 32'd8);
    check("run8_err", {31'b0, err}, 32'd0);
    check("run8_in_rdy_off", {31'b0, in_rdy}, 32'd0);
    // DONE ignores further producer activity.
    in_vld = 1'b1; in_data = 32'h18;
    repeat (2) @(posedge clk);
    #1; in_vld = 1'b0;
    check("done_hold_rx", {16'b0, rx_cnt}, 32'd8);
    check("done_hold_done", {31'b0, done}, 32'd1);

    // Word 3 corrupted.
    do_start(16'd8, 32'h10);
    feed(8, 32'h10, 3, 32'hDEAD, -1, '0, cyc, stl);
    check("bad_err", {31'b0, err}, 32'd1);
    check("bad_err_cnt", {16'b0, err_cnt}, 32'd1);
    check("bad_first", first_err_data, 32'hDEAD);
    check("bad_rx_cnt", {16'b0, rx_cnt}, 32'd8);

    // Two errors: only the first mismatching word is captured.
    do_start(16'd4, 32'h40);
    feed(4, 32'h40, 1, 32'hBEEF, 2, 32'hCAFE, cyc, stl);
    check("two_err_cnt", {16'b0, err_cnt}, 32'd2);
    check("two_first", first_err_data, 32'hBEEF);

    // Wrap of the expected value; previous errors must be cleared.
    do_start(16'd4, 32'hFFFF_FFFE);
    check("wrap_cleared_err", {31'b0, err}, 32'd0);
    check("wrap_cleared_first", first_err_data, 32'd0);
    feed(4, 32'hFFFF_FFFE, -1, '0, -1, '0, cyc, stl);
    check("wrap_err_cnt", {16'b0, err_cnt}, 32'd0);
    check("wrap_rx_cnt", {16'b0, rx_cnt}, 32'd4);
    check("wrap_done", {31'b0, done}, 32'd1);

    // Zero-length run: straight to DONE, never ready.
    do_start(16'd0, 32'h55);
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_rx_cnt", {16'b0, rx_cnt}, 32'd0);
    check("zero_in_rdy", {31'b0, in_rdy}, 32'd0);
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    check("zero_in_rdy_later", {31'b0, in_rdy}, 32'd0);
    check("zero_rx_cnt_later", {16'b0, rx_cnt}, 32'd0);

    // start held high during RUN must not restart the run.
    do_start(16'd4, 32'h100);
    start = 1'b1; seed = 32'h999; num_words = 16'd1;
    feed(4, 32'h100, -1, '0, -1, '0, cyc, stl);
    start = 1'b0;
    check("ign_start_rx", {16'b0, rx_cnt}, 32'd4);
    check("ign_start_err", {31'b0, err}, 32'd0);
    check("ign_start_done", {31'b0, done}, 32'd1);

    // 100-word run.
    do_start(16'd100, 32'h1000);
    feed(100, 32'h1000, -1, '0, -1, '0, cyc, stl);
`ifdef STREAM_CHK_BP_EN
    check("bp_stalled", 32'(stl > 0), 32'd1);
`else
    check("nobp_cycles", 32'(cyc), 32'd100);
`endif
    check("r100_rx_cnt", {16'b0, rx_cnt}, 32'd100);
    check("r100_err", {31'b0, err}, 32'd0);
    check("r100_done", {31'b0, done}, 32'd1);

    // Reset after 5 of 10 words, then a clean rerun.
    do_start(16'd10, 32'h500);
    feed(5, 32'h500, -1, '0, -1, '0, cyc, stl);
    check("mid_rx_cnt", {16'b0, rx_cnt}, 32'd5);
    #2 rstn = 1'b0;
    #1;
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_in_rdy", {31'b0, in_rdy}, 32'd0);
    check("mrst_rx_cnt", {16'b0, rx_cnt}, 32'd0);
    check("mrst_err", {31'b0, err}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    do_start(16'd10, 32'h500);
    feed(10, 32'h500, -1, '0, -1, '0, cyc, stl);
    check("rerun_rx_cnt", {16'b0, rx_cnt}, 32'd10);
    check("rerun_err_cnt", {16'b0, err_cnt}, 32'd0);
    check("rerun_done", {31'b0, done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
